// File: rtl/manchester_uart_rx.sv
`default_nettype none
// ============================================================================
// manchester_uart_rx : oversampling Manchester serial receiver, valid/ready out
// Rev 1.0
// ============================================================================
module manchester_uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 2,
  parameter int BAUDRATE  = 115200,
  parameter int CLK_FREQ  = 18_750_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_code_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int FULLBAUD    = CLK_FREQ / BAUDRATE;
  localparam int HALFBAUD    = FULLBAUD / 2;
  localparam int HUNT_THRESH = HALFBAUD + HALFBAUD / 2;
  localparam int LAST_DATA   = 2 * DATA_BITS;
  localparam int LAST_SAMPLE = 2 * (DATA_BITS + STOP_BITS);
  localparam int TGT_MAX     = HALFBAUD / 2 + (LAST_SAMPLE + 1) * HALFBAUD;
  localparam int CW          = $clog2(TGT_MAX + 1);
  localparam int HW          = $clog2(HUNT_THRESH + 1);
  localparam int SW          = $clog2(LAST_SAMPLE + 1);

  localparam logic [CW-1:0] C_FIRST_TGT   = CW'(HALFBAUD / 2);
  localparam logic [CW-1:0] C_HALF        = CW'(HALFBAUD);
  localparam logic [HW-1:0] C_HUNT        = HW'(HUNT_THRESH);
  localparam logic [SW-1:0] C_LAST_DATA   = SW'(LAST_DATA);
  localparam logic [SW-1:0] C_LAST_SAMPLE = SW'(LAST_SAMPLE);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync_q, rxs_q;
  logic [HW-1:0]          hunt_q, hunt_d;
  logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
  logic [CW-1:0]          tgt_q, tgt_d;
  logic [SW-1:0]          samp_q, samp_d;
  logic                   first_q, first_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   code_err_q, code_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= 1'b0;
      rxs_q       <= 1'b0;
      state_q     <= S_HUNT;
      hunt_q      <= '0;
      clk_cnt_q   <= '0;
      tgt_q       <= '0;
      samp_q      <= '0;
      first_q     <= 1'b0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      code_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= rx;
      rxs_q       <= sync_q;
      state_q     <= state_d;
      hunt_q      <= hunt_d;
      clk_cnt_q   <= clk_cnt_d;
      tgt_q       <= tgt_d;
      samp_q      <= samp_d;
      first_q     <= first_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      code_err_q  <= code_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hunt_d      = hunt_q;
    clk_cnt_d   = clk_cnt_q;
    tgt_d       = tgt_q;
    samp_d      = samp_q;
    first_d     = first_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    code_err_d  = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && rx_ready) valid_d = 1'b0;

    case (state_q)
      S_HUNT: begin
        // A high run longer than any idle half-cell marks idle-high + start-high
        if (!rxs_q) begin
          hunt_d = '0;
          if (hunt_q == C_HUNT) begin
            state_d   = S_RECV;
            clk_cnt_d = '0;
            tgt_d     = C_FIRST_TGT;
            samp_d    = '0;
          end
        end else if (hunt_q != C_HUNT) begin
          hunt_d = hunt_q + HW'(1);
        end
      end

      S_RECV: begin
        clk_cnt_d = clk_cnt_q + CW'(1);
        if (clk_cnt_q == tgt_q) begin
          tgt_d   = tgt_q + C_HALF;
          samp_d  = samp_q + SW'(1);
          first_d = rxs_q;
          if (samp_q == '0) begin
            if (rxs_q) begin
              frame_err_d = 1'b1;
              state_d     = S_HUNT;
            end
          end else if (!samp_q[0]) begin
            // Even sample closes a pair; odd sample was stored in first_q
            if (samp_q <= C_LAST_DATA) begin
              if (first_q == rxs_q) begin
                code_err_d = 1'b1;
                state_d    = S_HUNT;
              end else begin
                shift_d = {shift_q[DATA_BITS-2:0], rxs_q};
              end
            end else if (first_q || !rxs_q) begin
              frame_err_d = 1'b1;
              state_d     = S_HUNT;
            end else if (samp_q == C_LAST_SAMPLE) begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_HUNT;
        hunt_d  = '0;
        if (!valid_q || rx_ready) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end

      default: state_d = S_HUNT;
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_code_err  = code_err_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;

endmodule
`default_nettype wire
